// File: rtl/hms_clock_core.sv
// rtl/hms_clock_core.sv - H:M:S timekeeper with button setup; blink mask built only with HMS_BLINK_EN
module hms_clock_core #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DB_HZ    = 100,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_tick,
  output logic [2:0] o_blank
);

  localparam int DIV_N = CLK_HZ / DB_HZ;
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(DIV_N - 1);
  localparam logic [4:0]       HOUR_TC = 5'(HOUR_MAX);
  localparam logic [5:0]       MS_TC   = 6'd59;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       db_q, db_d;
  logic             armed_q, armed_d;
  logic [2:0]       press_q, press_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             mode_q, mode_d;
  logic [1:0]       pos_q, pos_d;
  logic             sec_tick_q, sec_tick_d;
  logic             tick, sample;
  logic             p_mode, p_pos, p_inc;

  assign tick   = (cnt_q == CNT_TC);
  assign sample = (div_q == DIV_TC);
  assign p_mode = press_q[2];
  assign p_pos  = press_q[1];
  assign p_inc  = press_q[0];

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    div_d      = sample ? '0 : div_q + DIV_W'(1);
    db_d       = db_q;
    armed_d    = armed_q;
    press_d    = 3'b000;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    mode_d     = mode_q;
    pos_d      = pos_q;
    sec_tick_d = 1'b0;

    // The first sample after reset only loads the level, so a button held
    // through reset release never produces a press.
    if (sample) begin
      db_d    = sync2_q;
      armed_d = 1'b1;
      if (armed_q) press_d = db_q & ~sync2_q;
    end

    if (!mode_q && tick) begin
      sec_tick_d = 1'b1;
      if (sec_q >= MS_TC) begin
        sec_d = 6'd0;
        if (min_q >= MS_TC) begin
          min_d  = 6'd0;
          hour_d = (hour_q >= HOUR_TC) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (p_mode) begin
      mode_d = ~mode_q;
      if (mode_q) cnt_d = '0;
    end else if (mode_q) begin
      if (p_inc) begin
        case (pos_q)
          2'd0: begin
            sec_d = (sec_q >= MS_TC) ? 6'd0 : sec_q + 6'd1;
            cnt_d = '0;
          end
          2'd1:    min_d  = (min_q >= MS_TC) ? 6'd0 : min_q + 6'd1;
          2'd2:    hour_d = (hour_q >= HOUR_TC) ? 5'd0 : hour_q + 5'd1;
          default: ;
        endcase
      end
      if (p_pos) pos_d = (pos_q >= 2'd2) ? 2'd0 : pos_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= '0;
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      db_q       <= 3'b111;
      armed_q    <= 1'b0;
      press_q    <= 3'b000;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      mode_q     <= 1'b0;
      pos_q      <= 2'd0;
      sec_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      sync1_q    <= {i_sw_mode, i_sw_pos, i_sw_inc};
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      armed_q    <= armed_d;
      press_q    <= press_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_sec_tick = sec_tick_q;

`ifdef HMS_BLINK_EN
  localparam int HALF = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 2;
  localparam int BL_W = $clog2(HALF);
  localparam logic [BL_W-1:0] BL_TC = BL_W'(HALF - 1);

  logic [BL_W-1:0] blk_cnt_q, blk_cnt_d;
  logic            blk_q, blk_d;

  // Phase restarts dark whenever setup is entered or the cursor moves.
  always_comb begin
    blk_cnt_d = blk_cnt_q + BL_W'(1);
    blk_d     = blk_q;
    if (!mode_d || !mode_q || (pos_d != pos_q)) begin
      blk_cnt_d = '0;
      blk_d     = 1'b0;
    end else if (blk_cnt_q == BL_TC) begin
      blk_cnt_d = '0;
      blk_d     = ~blk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      blk_q     <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blk_q     <= blk_d;
    end
  end

  assign o_blank = (mode_q && blk_q) ? (3'b001 << pos_q) : 3'b000;
`else
  assign o_blank = 3'b000;
`endif

endmodule

// File: tb/tb_hms_clock_core.sv
// tb/tb_hms_clock_core.sv - directed table and sequence bench for hms_clock_core
module tb_hms_clock_core;

  localparam int OP_MODE = 0;
  localparam int OP_POS  = 1;
  localparam int OP_INC  = 2;

  typedef struct {
    int op;
    int e_sec;
    int e_min;
    int e_hour;
    int e_mode;
    int e_pos;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sw_mode = 1'b1;
  logic       i_sw_pos = 1'b1;
  logic       i_sw_inc = 1'b1;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_sec_tick;
  logic [2:0] o_blank;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  hms_clock_core #(.CLK_HZ(1000), .DB_HZ(100), .HOUR_MAX(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw_mode(i_sw_mode), .i_sw_pos(i_sw_pos), .i_sw_inc(i_sw_inc),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode),
    .o_position(o_position), .o_sec_tick(o_sec_tick), .o_blank(o_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      OP_MODE: i_sw_mode = v;
      OP_POS:  i_sw_pos  = v;
      default: i_sw_inc  = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b0);
    repeat (hold) @(negedge clk);
    set_btn(which, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic press_n(input int which, input int n);
    for (int k = 0; k < n; k++) press(which, 20);
  endtask

  task automatic chk_time(input string name, input int s, input int m, input int h);
    chk({name, "_sec"}, o_sec, s);
    chk({name, "_min"}, o_min, m);
    chk({name, "_hour"}, o_hour, h);
  endtask

  vec_t vecs[10];

  initial begin
    int ticks, first_tick, found, n, seen_nz, mode_seen;

    vecs[0] = '{OP_MODE, 3, 0, 0, 1, 0};
    vecs[1] = '{OP_POS,  3, 0, 0, 1, 1};
    vecs[2] = '{OP_POS,  3, 0, 0, 1, 2};
    vecs[3] = '{OP_POS,  3, 0, 0, 1, 0};
    vecs[4] = '{OP_INC,  4, 0, 0, 1, 0};
    vecs[5] = '{OP_POS,  4, 0, 0, 1, 1};
    vecs[6] = '{OP_INC,  4, 1, 0, 1, 1};
    vecs[7] = '{OP_POS,  4, 1, 0, 1, 2};
    vecs[8] = '{OP_INC,  4, 1, 1, 1, 2};
    vecs[9] = '{OP_POS,  4, 1, 1, 1, 0};

    repeat (3) @(negedge clk);
    chk_time("reset", 0, 0, 0);
    chk("reset_mode", o_mode, 0);
    chk("reset_pos", o_position, 0);
    chk("reset_tick", o_sec_tick, 0);
    chk("reset_blank", o_blank, 0);
    rst_n = 1'b1;

    ticks = 0; first_tick = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (o_sec_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    chk_time("free_run", 3, 0, 0);
    chk("free_run_ticks", ticks, 3);
    chk("first_tick_cycle", first_tick, 1000);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].op, 20);
      chk($sformatf("vec%0d_sec", i), o_sec, vecs[i].e_sec);
      chk($sformatf("vec%0d_min", i), o_min, vecs[i].e_min);
      chk($sformatf("vec%0d_hour", i), o_hour, vecs[i].e_hour);
      chk($sformatf("vec%0d_mode", i), o_mode, vecs[i].e_mode);
      chk($sformatf("vec%0d_pos", i), o_position, vecs[i].e_pos);
    end

    // Short pulse sits entirely between two debounce samples.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cyc % 10 == 0) found = 1;
    end
    i_sw_inc = 1'b0;
    repeat (5) @(negedge clk);
    i_sw_inc = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_inc", o_sec, 4);
    press(OP_INC, 200);
    chk("long_hold_one_inc", o_sec, 5);

    press_n(OP_INC, 54);
    chk("sec_to_59", o_sec, 59);
    press(OP_INC, 20);
    chk_time("setup_sec_wrap", 0, 1, 1);
    press_n(OP_INC, 59);
    chk("sec_back_59", o_sec, 59);

    press(OP_POS, 20);
    chk("pos_min", o_position, 1);
`ifdef HMS_BLINK_EN
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (o_blank != 3'b000) found = 1;
    end
    chk("blink_on_mask", o_blank, 3'b010);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (o_blank == 3'b000) break;
    end
    chk("blink_half_period", n, 500);
`else
    seen_nz = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (o_blank != 3'b000) seen_nz = 1;
    end
    chk("blank_stays_zero", seen_nz, 0);
`endif

    press_n(OP_INC, 58);
    press(OP_POS, 20);
    press_n(OP_INC, 22);
    chk_time("preload", 59, 59, 23);
    chk("preload_pos", o_position, 2);
    press(OP_INC, 20);
    chk_time("setup_hour_wrap", 59, 59, 0);
    press_n(OP_INC, 23);
    chk("hour_back_23", o_hour, 23);

    i_sw_mode = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_mode == 1'b0) found = 1;
    end
    i_sw_mode = 1'b1;
    chk("exit_setup_seen", found, 1);
    chk_time("at_exit", 59, 59, 23);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (o_sec != 6'd59) break;
    end
    chk("first_second_len", n, 1000);
    chk_time("rollover", 0, 0, 0);
    chk("rollover_tick", o_sec_tick, 1);

    repeat (20) @(negedge clk);
    press(OP_MODE, 20);
    chk("reenter_mode", o_mode, 1);
    chk("pos_held", o_position, 2);
    press_n(OP_INC, 12);
    press(OP_POS, 20);
    press_n(OP_INC, 56);
    press(OP_POS, 20);
    press_n(OP_INC, 34);
    press(OP_MODE, 20);
    repeat (300) @(negedge clk);
    chk_time("mid_count", 56, 34, 12);
    chk("mid_count_mode", o_mode, 0);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    i_sw_mode = 1'b0;
    #1;
    chk_time("async_reset", 0, 0, 0);
    chk("async_reset_pos", o_position, 0);
    chk("async_reset_mode", o_mode, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ticks = 0; first_tick = -1; mode_seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (i == 100) i_sw_mode = 1'b1;
      if (o_mode) mode_seen = 1;
      if (o_sec_tick && first_tick < 0) first_tick = i;
    end
    chk("held_btn_no_press", mode_seen, 0);
    chk_time("resume", 1, 0, 0);
    chk("resume_first_tick", first_tick, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
